// File: rtl/out_mem_reader_pkg.sv
// Shared constants for the output-memory write/read controllers: layer codes,
// burst lengths and the reader state encoding.
package out_mem_reader_pkg;

  localparam logic [1:0] CONV_CODE = 2'b00;
  localparam logic [1:0] FC_CODE   = 2'b01;

  localparam int CONV_ROW_WORDS = 7;
  localparam int FC_WORDS       = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  function automatic logic cfg_legal(input logic [1:0] code);
    return (code == CONV_CODE) || (code == FC_CODE);
  endfunction

endpackage

// File: rtl/out_rd_skid_fifo.sv
// Small synchronous FIFO that absorbs out_mem read latency and DRAM backpressure.
// Head is visible combinationally; push and pop in one cycle keep the count.
module out_rd_skid_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 3,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_reg [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok  = pop && (count_reg != '0);
  assign push_ok = push && ((count_reg != CNT_W'(DEPTH)) || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop_ok)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/out_mem_reader.sv
// Drains out_mem addresses 0..N-1 to the DRAM write channel after each out_buf_ready.
// Optional OUT_MEM_READER_STALL_CNT_EN adds a saturating stall_cycles counter.
module out_mem_reader
  import out_mem_reader_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 13,
  parameter int MEM_LAT = 1,
  parameter int FIFO_D  = MEM_LAT + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        conv_or_fc,
  input  logic              out_buf_ready,
  output logic [ADDR_W-1:0] out_mem_rd_addr,
  output logic              en_out_mem_rd,
  input  logic [DATA_W-1:0] out_mem_rdata,
  output logic              dram_wvalid,
  output logic [DATA_W-1:0] dram_wdata,
  output logic              dram_wlast,
  input  logic              dram_wready,
  output logic              busy,
  output logic              done,
  output logic              err_cfg
`ifdef OUT_MEM_READER_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  localparam int CNT_W = $clog2(FIFO_D + 1);

  rd_state_t         state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, last_addr_reg;
  logic [MEM_LAT-1:0] tag_vld_reg, tag_last_reg;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  inflight_sum [MEM_LAT+1];
  logic [DATA_W:0]   fifo_head;
  logic              done_reg, err_reg;
  logic              start_ok, start_err, credit_ok, issue, issue_last, beat, beat_last;

  assign start_ok  = out_buf_ready && (state_reg == IDLE) && cfg_legal(conv_or_fc);
  assign start_err = out_buf_ready && !start_ok;

  assign inflight_sum[0] = '0;
  for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_inflight
    assign inflight_sum[gi+1] = inflight_sum[gi] + CNT_W'(tag_vld_reg[gi]);
  end

  // A read is only issued when its word is guaranteed a FIFO slot on return.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight_sum[MEM_LAT]}) < (CNT_W + 1)'(FIFO_D);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    case (state_reg)
      IDLE:  if (start_ok) state_next = READ;
      READ: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (addr_reg == last_addr_reg) state_next = DRAIN;
        end
      end
      DRAIN: if (beat_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign issue_last      = issue && (addr_reg == last_addr_reg);
  assign en_out_mem_rd   = issue;
  assign out_mem_rd_addr = addr_reg;
  assign busy            = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg      <= '0;
      last_addr_reg <= '0;
    end else if (start_ok) begin
      addr_reg      <= '0;
      last_addr_reg <= (conv_or_fc == FC_CODE) ? ADDR_W'(FC_WORDS - 1)
                                               : ADDR_W'(CONV_ROW_WORDS - 1);
    end else if (issue && !issue_last) begin
      addr_reg <= addr_reg + 1'b1;
    end
  end

  // Tags travel alongside the memory pipeline so each returning word is pushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_reg  <= '0;
      tag_last_reg <= '0;
    end else begin
      tag_vld_reg  <= MEM_LAT'({tag_vld_reg, issue});
      tag_last_reg <= MEM_LAT'({tag_last_reg, issue_last});
    end
  end

  out_rd_skid_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_vld_reg[MEM_LAT-1]),
    .push_data ({tag_last_reg[MEM_LAT-1], out_mem_rdata}),
    .pop       (beat),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign dram_wvalid = (fifo_count != '0);
  assign dram_wdata  = fifo_head[DATA_W-1:0];
  assign dram_wlast  = dram_wvalid && fifo_head[DATA_W];
  assign beat        = dram_wvalid && dram_wready;
  assign beat_last   = beat && dram_wlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      done_reg <= (state_reg == DRAIN) && beat_last;
      err_reg  <= start_err;
    end
  end

  assign done    = done_reg;
  assign err_cfg = err_reg;

`ifdef OUT_MEM_READER_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (start_ok) begin
      stall_cnt_reg <= '0;
    end else if (dram_wvalid && !dram_wready && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_cycles = stall_cnt_reg;
`endif

endmodule
